// File: rtl/reduceron_io_sink.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : reduceron_io_sink                                            |
// | Brief    : Reduceron IO write sink; queues TX_ADDR bytes in a FIFO and  |
// |            sends them as 8N1 serial on txd. IOSINK_LEDS_EN adds an      |
// |            8-bit LED register at LED_ADDR.                              |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
module reduceron_io_sink #(
   parameter int          DIVISOR   = 434,
   parameter int          FIFO_LOG2 = 4,
   parameter logic [14:0] TX_ADDR   = 15'd0,
   parameter logic [14:0] LED_ADDR  = 15'd1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        iowrite,
   input  logic [14:0] ioaddr,
   input  logic [14:0] iowd,
   output logic        txd,
   output logic        busy,
   output logic        full,
   output logic        overflow
`ifdef IOSINK_LEDS_EN
   ,
   output logic [7:0]  leds
`endif
);

   localparam int                 C_DEPTH   = 1 << FIFO_LOG2;
   localparam logic [15:0]        C_RELOAD  = 16'(DIVISOR - 1);
   localparam logic [FIFO_LOG2:0] C_FULL    = (FIFO_LOG2 + 1)'(C_DEPTH);
   localparam logic [FIFO_LOG2:0] C_CNT_ONE = (FIFO_LOG2 + 1)'(1);
   localparam logic [FIFO_LOG2-1:0] C_PTR_ONE = FIFO_LOG2'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t               r_state, w_state_nx;
   logic [15:0]          r_baud, w_baud_nx;
   logic [2:0]           r_bit, w_bit_nx;
   logic [7:0]           r_shift, w_shift_nx;
   logic                 r_txd, w_txd_nx;
   logic                 w_pop;

   logic [7:0]           r_mem [C_DEPTH];
   logic [FIFO_LOG2-1:0] r_rd_ptr, r_wr_ptr;
   logic [FIFO_LOG2:0]   r_count;
   logic                 r_overflow;
   logic                 w_push_req, w_push;

   assign w_push_req = iowrite && (ioaddr == TX_ADDR);
   assign full       = (r_count == C_FULL);
   // A full FIFO still accepts a byte when the transmitter frees a slot on this edge.
   assign w_push     = w_push_req && (!full || w_pop);
   assign busy       = (r_count != '0) || (r_state != S_IDLE);
   assign txd        = r_txd;
   assign overflow   = r_overflow;

   always_comb begin
      w_state_nx = r_state;
      w_baud_nx  = r_baud;
      w_bit_nx   = r_bit;
      w_shift_nx = r_shift;
      w_pop      = 1'b0;
      w_txd_nx   = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (r_count != '0) begin
               w_pop      = 1'b1;
               w_shift_nx = r_mem[r_rd_ptr];
               w_bit_nx   = 3'd0;
               w_baud_nx  = C_RELOAD;
               w_state_nx = S_START;
            end
         end
         S_START: begin
            if (r_baud == '0) begin
               w_baud_nx  = C_RELOAD;
               w_state_nx = S_DATA;
            end else begin
               w_baud_nx = r_baud - 16'd1;
            end
         end
         S_DATA: begin
            if (r_baud == '0) begin
               w_baud_nx  = C_RELOAD;
               w_shift_nx = {1'b0, r_shift[7:1]};
               w_bit_nx   = r_bit + 3'd1;
               if (r_bit == 3'd7) begin
                  w_state_nx = S_STOP;
               end
            end else begin
               w_baud_nx = r_baud - 16'd1;
            end
         end
         S_STOP: begin
            if (r_baud == '0) begin
               w_state_nx = S_IDLE;
            end else begin
               w_baud_nx = r_baud - 16'd1;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
      // Line level is registered from the upcoming state so txd changes on the state edge.
      case (w_state_nx)
         S_START: w_txd_nx = 1'b0;
         S_DATA:  w_txd_nx = w_shift_nx[0];
         default: w_txd_nx = 1'b1;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_baud     <= '0;
         r_bit      <= '0;
         r_shift    <= '0;
         r_txd      <= 1'b1;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_baud  <= w_baud_nx;
         r_bit   <= w_bit_nx;
         r_shift <= w_shift_nx;
         r_txd   <= w_txd_nx;
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + C_CNT_ONE;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - C_CNT_ONE;
         end
         if (w_push_req && !w_push) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Storage needs no reset; emptiness is tracked by r_count alone.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= iowd[7:0];
      end
   end

`ifdef IOSINK_LEDS_EN
   logic [7:0] r_leds;
   logic       w_unused;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_leds <= '0;
      end else if (iowrite && (ioaddr == LED_ADDR)) begin
         r_leds <= iowd[7:0];
      end
   end

   assign leds     = r_leds;
   assign w_unused = ^iowd[14:8];
`else
   logic w_unused;
   assign w_unused = ^{iowd[14:8], LED_ADDR};
`endif

endmodule
`default_nettype wire
